// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: widths, the NOP encoding and fetch FSM state codes.
// FETCH_MISALIGN_CHECK_EN (optional) enables the FAULT state in instruction_fetch.
package riscv_pkg;

    localparam int XLEN    = 64;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t ST_REQ   = 3'd0;
    localparam fetch_state_t ST_WAIT  = 3'd1;
    localparam fetch_state_t ST_HOLD  = 3'd2;
    localparam fetch_state_t ST_DRAIN = 3'd3;
    localparam fetch_state_t ST_FAULT = 3'd4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: reset load, redirect load and sequential increment (redirect wins over increment).
module fetch_pc_reg #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    input  logic            load,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            // Wraps modulo 2^XLEN by construction.
            pc <= pc + XLEN'(PC_STEP);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC-driven instruction memory reads into a 1-entry buffer handed to decode.
// FETCH_MISALIGN_CHECK_EN adds a sticky misaligned-redirect fault (fetch_misaligned port, FAULT state).
module instruction_fetch import riscv_pkg::*; #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [XLEN-1:0]    instr_pc,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_target
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic               fetch_misaligned
`endif
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            outstanding;
    logic            pc_inc;
    logic            capture;
    logic            consume;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic            fault_pend;

    assign target     = redirect_target;
    assign misaligned = redirect_target[1:0] != 2'b00;
`else
    assign target     = redirect_target & ~XLEN'(2'b11);
    assign misaligned = 1'b0;
`endif

    assign imem_req_valid = (state == ST_REQ) && !reset;
    assign imem_addr      = pc;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk    (clk),
        .reset  (reset),
        .inc    (pc_inc),
        .load   (redirect_valid),
        .target (target),
        .pc     (pc)
    );

    // A request whose response has not been seen by the end of this cycle; a redirect must drain it.
    always_comb begin
        outstanding = ((state == ST_REQ) && imem_req_ready) ||
                      (((state == ST_WAIT) || (state == ST_DRAIN)) && !imem_resp_valid);
`ifdef FETCH_MISALIGN_CHECK_EN
        if ((state == ST_FAULT) && fault_pend && !imem_resp_valid) begin
            outstanding = 1'b1;
        end
`endif
    end

    always_comb begin
        state_next = state;
        pc_inc     = 1'b0;
        capture    = 1'b0;
        consume    = 1'b0;
        if (redirect_valid) begin
            if (misaligned) begin
                state_next = ST_FAULT;
            end else begin
                state_next = outstanding ? ST_DRAIN : ST_REQ;
            end
        end else begin
            case (state)
                ST_REQ:   if (imem_req_ready) state_next = ST_WAIT;
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        capture    = 1'b1;
                        pc_inc     = 1'b1;
                        state_next = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        consume    = 1'b1;
                        state_next = ST_REQ;
                    end
                end
                ST_DRAIN: if (imem_resp_valid) state_next = ST_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
                ST_FAULT: state_next = ST_FAULT;
`endif
                default:  state_next = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_REQ;
            instr_valid <= 1'b0;
            instruction <= NOP_INSTR;
            instr_pc    <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                instr_valid <= 1'b0;
            end else if (capture) begin
                instr_valid <= 1'b1;
                instruction <= imem_resp_data;
                instr_pc    <= pc;
            end else if (consume) begin
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // FAULT keeps absorbing the response of a request accepted before the misaligned redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_misaligned <= 1'b0;
            fault_pend       <= 1'b0;
        end else if (redirect_valid) begin
            fetch_misaligned <= misaligned;
            fault_pend       <= misaligned && outstanding;
        end else if ((state == ST_FAULT) && imem_resp_valid) begin
            fault_pend       <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a reference fetch model and a latency-programmable memory.
// Define FETCH_MISALIGN_CHECK_EN to also exercise the misaligned-redirect fault.
module tb_instruction_fetch;

    localparam int XLEN = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_resp_valid;
    logic [31:0]       imem_resp_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instruction;
    logic [XLEN-1:0]   instr_pc;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_target;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic              fetch_misaligned;
`endif

    always #5 clk = ~clk;

    instruction_fetch #(
        .XLEN     (XLEN),
        .RESET_PC (64'h0),
        .PC_STEP  (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instruction     (instruction),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misaligned(fetch_misaligned)
`endif
    );

    int checks = 0;
    int failures = 0;

    int          lat = 0;
    bit          mem_ready_en = 1'b1;
    bit          poison = 1'b0;
    logic [63:0] acc_q[$];
    int          hs_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory content: word derived from its address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[31:2], 2'b11};
    endfunction

    // Memory: one response per accepted request after 'lat' extra cycles.
    initial begin : memory
        bit          acc;
        bit          rst_seen;
        bit          pending;
        int          cnt;
        logic [63:0] a;
        logic [63:0] pa;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        pending = 1'b0;
        cnt = 0;
        pa = '0;
        forever begin
            @(negedge clk);
            acc      = imem_req_valid && imem_req_ready;
            a        = imem_addr;
            rst_seen = (reset === 1'b1);
            if (acc) acc_q.push_back(a);
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            if (rst_seen) pending = 1'b0;
            if (acc && !rst_seen) begin
                pending = 1'b1;
                cnt = lat;
                pa = a;
            end
            if (pending) begin
                if (cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = poison ? 32'hDEADBEEF : mem_word(pa);
                    poison  = 1'b0;
                    pending = 1'b0;
                end else begin
                    cnt--;
                end
            end
            imem_req_ready = mem_ready_en;
        end
    end

    // Reference model: the next instruction decode should see is the one at exp_pc.
    initial begin : model
        logic [63:0] exp_pc;
        bit          mfault;
        int          cyc;
        exp_pc = '0;
        mfault = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset === 1'b1) begin
                chk("req_valid_in_reset", 64'(imem_req_valid), 64'd0);
                exp_pc = 64'h0;
                mfault = 1'b0;
                continue;
            end
            if (instr_valid) begin
                chk("model_instr_pc", instr_pc, exp_pc);
                chk("model_instruction", 64'(instruction), 64'(mem_word(exp_pc)));
            end
            if (imem_req_valid) chk("model_req_addr", imem_addr, exp_pc);
            chk("model_req_and_buffer_exclusive", 64'(imem_req_valid && instr_valid), 64'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
            chk("model_misaligned_flag", 64'(fetch_misaligned), 64'(mfault));
            if (mfault) chk("model_no_req_in_fault", 64'(imem_req_valid), 64'd0);
`endif
            if (redirect_valid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                exp_pc = redirect_target;
                mfault = redirect_target[1:0] != 2'b00;
`else
                exp_pc = redirect_target & ~64'h3;
`endif
            end else if (instr_valid && instr_ready) begin
                hs_q.push_back(cyc);
                exp_pc = exp_pc + 64'd4;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (instr_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_acc(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) ok = 1'b1;
        end
    endtask

    task automatic wait_new_acc(input int s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (acc_q.size() > s) ok = 1'b1;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        bit          ok;
        bit          seen_fc;
        bit          got;
        int          s;
        logic [31:0] snap_i;
        logic [63:0] snap_pc;
        logic [15:0] pat;

        reset = 1'b1;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = '0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset_instr_valid", 64'(instr_valid), 64'd0);
        chk("reset_instruction", 64'(instruction), 64'h13);
        chk("reset_instr_pc", instr_pc, 64'h0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("first_req_addr", imem_addr, 64'h0);

        // Streaming at zero latency
        repeat (12) @(negedge clk);
        chk("stream_acc_count_ge3", 64'(acc_q.size() >= 3), 64'd1);
        chk("stream_hs_count_ge3", 64'(hs_q.size() >= 3), 64'd1);
        if (acc_q.size() >= 3 && hs_q.size() >= 3) begin
            chk("stream_addr0", acc_q[0], 64'h0);
            chk("stream_addr1", acc_q[1], 64'h4);
            chk("stream_addr2", acc_q[2], 64'h8);
            chk("stream_period1", 64'(hs_q[1] - hs_q[0]), 64'd3);
            chk("stream_period2", 64'(hs_q[2] - hs_q[1]), 64'd3);
        end

        // Backpressure in HOLD
        tick();
        instr_ready = 1'b0;
        wait_valid(ok);
        chk("bp_reached_hold", 64'(ok), 64'd1);
        snap_i = instruction;
        snap_pc = instr_pc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_stable", 64'(instr_valid), 64'd1);
            chk("bp_instr_stable", 64'(instruction), 64'(snap_i));
            chk("bp_pc_stable", instr_pc, snap_pc);
            chk("bp_no_request", 64'(imem_req_valid), 64'd0);
        end
        tick();
        instr_ready = 1'b1;

        // Redirect while waiting; the stale word is poisoned and must be dropped
        lat = 2;
        wait_acc(ok);
        chk("wait_redir_req_seen", 64'(ok), 64'd1);
        tick();
        poison = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 64'h100;
        s = acc_q.size();
        tick();
        redirect_valid = 1'b0;
        wait_new_acc(s, ok);
        lat = 0;
        chk("wait_redir_new_req", 64'(ok), 64'd1);
        if (ok) chk("wait_redir_req_addr", acc_q[s], 64'h100);
        wait_valid(ok);
        chk("wait_redir_delivered", 64'(ok), 64'd1);
        chk("wait_redir_instr_pc", instr_pc, 64'h100);
        chk("wait_redir_instruction", 64'(instruction), 64'h00000103);

        // Redirect in HOLD with instr_ready in the same cycle
        tick();
        instr_ready = 1'b0;
        wait_valid(ok);
        chk("hold_redir_reached", 64'(ok), 64'd1);
        tick();
        redirect_valid = 1'b1;
        redirect_target = 64'h40;
        instr_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("hold_redir_valid_dropped", 64'(instr_valid), 64'd0);
        chk("hold_redir_req_valid", 64'(imem_req_valid), 64'd1);
        chk("hold_redir_req_addr", imem_addr, 64'h40);

        // PC wrap at the top of the address space
        tick();
        redirect_valid = 1'b1;
        redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        s = acc_q.size();
        seen_fc = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (acc_q.size() > s) begin
                if (seen_fc) begin
                    chk("wrap_next_addr", acc_q[s], 64'h0);
                    got = 1'b1;
                end else if (acc_q[s] == 64'hFFFF_FFFF_FFFF_FFFC) begin
                    seen_fc = 1'b1;
                end
                s++;
            end
        end
        chk("wrap_observed", 64'(got), 64'd1);

        // Reset asserted while waiting for a response
        lat = 2;
        wait_acc(ok);
        chk("rst_wait_req_seen", 64'(ok), 64'd1);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_wait_req_low", 64'(imem_req_valid), 64'd0);
        tick();
        reset = 1'b0;
        lat = 0;
        @(negedge clk);
        chk("rst_wait_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_wait_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rst_wait_req_addr", imem_addr, 64'h0);

        // Mixed latency and decode backpressure
        pat = 16'b1011_0010_1110_0101;
        for (int i = 0; i < 48; i++) begin
            tick();
            instr_ready = pat[i % 16];
            lat = i % 3;
        end
        tick();
        instr_ready = 1'b1;
        lat = 0;
        repeat (6) @(negedge clk);

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned redirect faults; an aligned redirect recovers
        tick();
        redirect_valid = 1'b1;
        redirect_target = 64'h102;
        tick();
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("fault_flag_set", 64'(fetch_misaligned), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("fault_no_request", 64'(imem_req_valid), 64'd0);
        end
        tick();
        redirect_valid = 1'b1;
        redirect_target = 64'h200;
        s = acc_q.size();
        tick();
        redirect_valid = 1'b0;
        wait_new_acc(s, ok);
        chk("fault_recover_req", 64'(ok), 64'd1);
        if (ok) chk("fault_recover_addr", acc_q[s], 64'h200);
        chk("fault_flag_clear", 64'(fetch_misaligned), 64'd0);
        repeat (6) @(negedge clk);
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
